// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared command and state encodings for the one-hot decoder
//
// Purpose: command codes carried on in_cmd and the two-state FSM encoding.
// Ports:   none (package).
package dec_pkg;

   typedef enum logic [1:0] {
      CMD_LOAD  = 2'b00,
      CMD_ROTL  = 2'b01,
      CMD_ROTR  = 2'b10,
      CMD_CLEAR = 2'b11
   } cmd_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/dec_scan_prescaler.sv
// rtl/dec_scan_prescaler.sv - modulo-SCAN_DIV step counter with hold and clear
//
// Purpose: paces auto-scan rotates. Counts 0..SCAN_DIV-1 and sits at the
//          terminal count until the owner reports that the step was taken.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clear_i    force count to 0 (scan disabled, IDLE, or command accepted)
//   advance_i  the terminal-count step was performed this cycle
//   tc_o       count is at SCAN_DIV-1
module dec_scan_prescaler #(
   parameter int SCAN_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic advance_i,
   output logic tc_o
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (cnt_q == TC) begin
         // Hold at terminal count until the step actually goes out.
         if (advance_i) begin
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered one-hot select with rotate/clear and valid/ready output
//
// Purpose: decodes an SEL_W-bit index into a 2**SEL_W one-hot word held in a
//          state register; later commands rotate (with wrap) or clear it.
//          Results leave through a single-register valid/ready stage.
// Optional: DEC_AUTOSCAN_EN adds scan_en and a SCAN_DIV-paced internal ROTL.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              command handshake
//   in_cmd, in_sel                 command code, LOAD index
//   out_valid/out_ready            result handshake
//   out_y, out_idx, out_err        one-hot word, its index, rotate-in-IDLE flag
//   scan_en                        (DEC_AUTOSCAN_EN only) enable auto-scan
module onehot_decoder_seq
   import dec_pkg::*;
#(
   parameter int SEL_W = 2
`ifdef DEC_AUTOSCAN_EN
   ,
   parameter int SCAN_DIV = 4
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_cmd,
   input  logic [SEL_W-1:0]        in_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [(1<<SEL_W)-1:0]   out_y,
   output logic [SEL_W-1:0]        out_idx,
   output logic                    out_err
`ifdef DEC_AUTOSCAN_EN
   ,
   input  logic                    scan_en
`endif
);

   localparam int OUT_W = 1 << SEL_W;

   state_t             state_q, state_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic               err_q, err_d;
   logic               valid_q, valid_d;

   logic               accept;
   logic               scan_fire;
   cmd_t               cmd;

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [OUT_W-1:0] y;
      y      = '0;
      y[idx] = 1'b1;
      return y;
   endfunction

   assign cmd      = cmd_t'(in_cmd);
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

`ifdef DEC_AUTOSCAN_EN
   logic scan_tc;
   logic scan_clear;

   // Accepted commands win over the scan step and restart its interval.
   assign scan_clear = !scan_en || (state_q != ST_ACTIVE) || accept;
   assign scan_fire  = scan_en && (state_q == ST_ACTIVE) && scan_tc && !accept && in_ready;

   dec_scan_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (scan_clear),
      .advance_i (scan_fire),
      .tc_o      (scan_tc)
   );
`else
   assign scan_fire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      idx_d   = idx_q;
      err_d   = err_q;
      valid_d = valid_q;
      if (accept) begin
         valid_d = 1'b1;
         err_d   = 1'b0;
         case (cmd)
            CMD_LOAD: begin
               state_d = ST_ACTIVE;
               idx_d   = in_sel;
               y_d     = onehot(in_sel);
            end
            CMD_ROTL, CMD_ROTR: begin
               if (state_q == ST_ACTIVE) begin
                  // Index width equals log2(OUT_W), so +/-1 wraps naturally.
                  if (cmd == CMD_ROTL) begin
                     idx_d = idx_q + SEL_W'(1);
                     y_d   = {y_q[OUT_W-2:0], y_q[OUT_W-1]};
                  end else begin
                     idx_d = idx_q - SEL_W'(1);
                     y_d   = {y_q[0], y_q[OUT_W-1:1]};
                  end
               end else begin
                  y_d   = '0;
                  idx_d = '0;
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               y_d     = '0;
               idx_d   = '0;
            end
         endcase
      end else if (scan_fire) begin
         valid_d = 1'b1;
         err_d   = 1'b0;
         idx_d   = idx_q + SEL_W'(1);
         y_d     = {y_q[OUT_W-2:0], y_q[OUT_W-1]};
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         y_q     <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_y     = y_q;
   assign out_idx   = idx_q;
   assign out_err   = err_q;

endmodule
